// File: rtl/cla_pipe_addsub.sv
// Two-stage pipelined add/sub built from 4-bit carry-lookahead groups; latency 2, one op per cycle.
// Valid/ready on both sides; stalls propagate back when the output is held. Optional ovf under CLA_OVF_EN.
module cla_pipe_addsub #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             co
`ifdef CLA_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int NG = WIDTH / 4;

    logic             s1_valid;
    logic [WIDTH-1:0] a1;
    logic [WIDTH-1:0] b1;
    logic             c01;
    logic             s2_adv;
    logic             s1_adv;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv && !reset;

    // Subtraction is folded into S1 as a + ~b + 1, so cin is dropped for sub.
    always_ff @(posedge clk) begin
        if (reset) begin
            s1_valid <= 1'b0;
            a1       <= '0;
            b1       <= '0;
            c01      <= 1'b0;
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                a1  <= a;
                b1  <= sub ? ~b : b;
                c01 <= sub | cin;
            end
        end
    end

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [NG-1:0]    gg;
    logic [NG-1:0]    gp;
    logic [NG:0]      gc;
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum;
    logic             acc;
    logic             pr;

    assign g = a1 & b1;
    assign p = a1 ^ b1;

    always_comb begin
        gg = '0;
        gp = '0;
        for (int k = 0; k < NG; k++) begin
            gp[k] = &p[4*k +: 4];
            gg[k] = g[4*k+3]
                  | (p[4*k+3] & g[4*k+2])
                  | (p[4*k+3] & p[4*k+2] & g[4*k+1])
                  | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
        end
    end

    // Each group carry-in is a flat sum-of-products over all lower groups' G/P.
    always_comb begin
        gc    = '0;
        acc   = 1'b0;
        pr    = 1'b1;
        gc[0] = c01;
        for (int k = 1; k <= NG; k++) begin
            acc = 1'b0;
            pr  = 1'b1;
            for (int j = k - 1; j >= 0; j--) begin
                acc = acc | (gg[j] & pr);
                pr  = pr & gp[j];
            end
            gc[k] = acc | (pr & c01);
        end
    end

    always_comb begin
        c = '0;
        for (int k = 0; k < NG; k++) begin
            c[4*k]   = gc[k];
            c[4*k+1] = g[4*k] | (p[4*k] & gc[k]);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & gc[k]);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & gc[k]);
        end
        c[WIDTH] = gc[NG];
    end

    assign sum = p ^ c[WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            s         <= '0;
            co        <= 1'b0;
`ifdef CLA_OVF_EN
            ovf       <= 1'b0;
`endif
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            s         <= sum;
            co        <= c[WIDTH];
`ifdef CLA_OVF_EN
            ovf       <= c[WIDTH] ^ c[WIDTH-1];
`endif
        end
    end

endmodule

// File: tb/tb_cla_pipe_addsub.sv
// Randomized and directed checks of cla_pipe_addsub against an arithmetic reference model.
module tb_cla_pipe_addsub;
    localparam int W = 32;
`ifdef CLA_OVF_EN
    localparam bit HAS_OVF = 1'b1;
`else
    localparam bit HAS_OVF = 1'b0;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic         in_valid = 0, in_ready, cin = 0, sub = 0, out_valid, out_ready = 1, co, ovf_mon;
    logic [W-1:0] a = '0, b = '0, s;
    logic         in_valid4 = 0, in_ready4, out_valid4, co4, ovf4_mon;
    logic [3:0]   a4 = '0, b4 = '0, s4;
    logic         in_valid64 = 0, in_ready64, out_valid64, co64, ovf64_mon;
    logic [63:0]  a64 = '0, b64 = '0, s64;

`ifdef CLA_OVF_EN
    logic ovf, ovf4, ovf64;
    assign ovf_mon = ovf;
    assign ovf4_mon = ovf4;
    assign ovf64_mon = ovf64;
`else
    assign ovf_mon = 1'b0;
    assign ovf4_mon = 1'b0;
    assign ovf64_mon = 1'b0;
`endif

    cla_pipe_addsub #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
        .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .s(s), .co(co)
`ifdef CLA_OVF_EN
        , .ovf(ovf)
`endif
    );
    cla_pipe_addsub #(.WIDTH(4)) dut4 (
        .clk(clk), .reset(reset), .in_valid(in_valid4), .in_ready(in_ready4), .a(a4), .b(b4),
        .cin(1'b0), .sub(1'b0), .out_valid(out_valid4), .out_ready(1'b1), .s(s4), .co(co4)
`ifdef CLA_OVF_EN
        , .ovf(ovf4)
`endif
    );
    cla_pipe_addsub #(.WIDTH(64)) dut64 (
        .clk(clk), .reset(reset), .in_valid(in_valid64), .in_ready(in_ready64), .a(a64), .b(b64),
        .cin(1'b0), .sub(1'b0), .out_valid(out_valid64), .out_ready(1'b1), .s(s64), .co(co64)
`ifdef CLA_OVF_EN
        , .ovf(ovf64)
`endif
    );

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;
    int n_out = 0;
    bit lat_chk = 0;

    typedef struct {
        logic [W+1:0] r;
        int           t;
    } exp_t;
    exp_t q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Result packed as {ovf, co, s}; computed from plain signed/unsigned arithmetic.
    function automatic logic [W+1:0] model(input logic [W-1:0] x, input logic [W-1:0] y,
                                           input logic ci, input logic sb);
        logic signed [W+1:0] sx, sy, r;
        logic [W:0]          full;
        logic [W-1:0]        rs;
        logic                rc, ro;
        sx = $signed({{2{x[W-1]}}, x});
        sy = $signed({{2{y[W-1]}}, y});
        if (sb) begin
            r  = sx - sy;
            rs = x - y;
            rc = (x >= y);
        end else begin
            r    = sx + sy + $signed({{(W+1){1'b0}}, ci});
            full = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci};
            rs   = full[W-1:0];
            rc   = full[W];
        end
        ro = !((r[W+1] == r[W]) && (r[W] == r[W-1]));
        return {ro, rc, rs};
    endfunction

    function automatic logic [W+1:0] mask(input logic [W+1:0] v);
        logic [W+1:0] m;
        m = v;
        if (!HAS_OVF) m[W+1] = 1'b0;
        return m;
    endfunction

    logic         pv = 0, prdy = 0, prst = 1;
    logic [W+1:0] prev_r = '0;

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            q.delete();
        end else begin
            if (pv && !prdy && !prst) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", {ovf_mon, co, s}, prev_r);
            end
            if (in_valid && in_ready) begin
                e.r = mask(model(a, b, cin, sub));
                e.t = cyc;
                q.push_back(e);
            end
            if (out_valid && out_ready) begin
                check("out_has_pending", q.size() != 0, 1);
                if (q.size() != 0) begin
                    e = q.pop_front();
                    check("result", {ovf_mon, co, s}, e.r);
                    if (lat_chk) check("latency", cyc - e.t, 2);
                end
                n_out++;
            end
        end
        pv     = out_valid;
        prdy   = out_ready;
        prst   = reset;
        prev_r = {ovf_mon, co, s};
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic sb);
        int n;
        a = x; b = y; cin = ci; sub = sb; in_valid = 1'b1;
        n = 0;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        if (n >= 50) check("send_timeout", 1, 0);
        step();
        in_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        int n0;
        check("model_add_wrap", model(32'hFFFFFFFF, 32'h1, 1'b0, 1'b0), 34'h1_0000_0000);
        check("model_sub_ovf", model(32'h80000000, 32'h1, 1'b1, 1'b1), 34'h3_7FFF_FFFF);
        check("model_add_ovf", model(32'h7FFFFFFF, 32'h0, 1'b1, 1'b0), 34'h2_8000_0000);
        check("model_sub_borrow", model(32'h1, 32'h2, 1'b0, 1'b1), 34'h0_FFFF_FFFF);

        reset = 1'b1;
        step(); step(); step();
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_s", {ovf_mon, co, s}, 0);
        reset = 1'b0;
        #1;
        check("post_rst_in_ready", in_ready, 1);

        // Wrap-around add at all three widths.
        a = 32'hFFFFFFFF; b = 32'h1; cin = 0; sub = 0; in_valid = 1;
        a4 = 4'hF; b4 = 4'h1; in_valid4 = 1;
        a64 = 64'hFFFF_FFFF_FFFF_FFFF; b64 = 64'h1; in_valid64 = 1;
        check("w4_in_ready", in_ready4, 1);
        check("w64_in_ready", in_ready64, 1);
        step();
        in_valid = 0; in_valid4 = 0; in_valid64 = 0;
        check("lat1_no_out", out_valid, 0);
        step();
        check("add_wrap_vld", out_valid, 1);
        check("add_wrap", {ovf_mon, co, s}, 34'h1_0000_0000);
        check("w4_add_wrap", {out_valid4, ovf4_mon, co4, s4}, 7'b1_0_1_0000);
        check("w64_add_wrap", {out_valid64, ovf64_mon, co64, s64}, {1'b1, 1'b0, 1'b1, 64'h0});

        send(32'h80000000, 32'h1, 1'b1, 1'b1);
        step();
        check("sub_ovf", {out_valid, ovf_mon, co, s}, {1'b1, HAS_OVF, 1'b1, 32'h7FFFFFFF});
        step();

        // Back-pressure: pipe fills after two transfers.
        out_ready = 0;
        send(1, 1, 0, 0);
        send(2, 2, 0, 0);
        check("bp_in_ready_low", in_ready, 0);
        a = 3; b = 3; cin = 0; sub = 0; in_valid = 1;
        step(); step();
        check("bp_still_blocked", in_ready, 0);
        out_ready = 1;
        #1;
        check("bp_in_ready_up", in_ready, 1);
        check("bp_s0", {out_valid, s}, {1'b1, 32'd2});
        step();
        in_valid = 0;
        check("bp_s1", {out_valid, s}, {1'b1, 32'd4});
        step();
        check("bp_s2", {out_valid, s}, {1'b1, 32'd6});
        step();
        check("bp_drained", out_valid, 0);

        // Reset with two ops in flight.
        out_ready = 0;
        send(32'h11, 32'h22, 0, 0);
        send(32'h33, 32'h44, 0, 0);
        reset = 1;
        step();
        check("midrst_in_ready", in_ready, 0);
        reset = 0;
        out_ready = 1;
        check("midrst_out_valid", out_valid, 0);
        for (int i = 0; i < 4; i++) begin
            step();
            check("midrst_no_stale", out_valid, 0);
        end

        // Full-rate stream.
        lat_chk = 1;
        n0 = n_out;
        for (int i = 0; i < 100; i++) begin
            a = $urandom; b = $urandom; cin = $urandom_range(0, 1); sub = $urandom_range(0, 1);
            if ($urandom_range(0, 7) == 0) a = 32'h80000000;
            if ($urandom_range(0, 7) == 0) b = 32'hFFFFFFFF;
            in_valid = 1;
            check("stream_in_ready", in_ready, 1);
            step();
        end
        in_valid = 0;
        step(); step(); step();
        lat_chk = 0;
        check("stream_count", n_out - n0, 100);

        // Random valid/ready patterns.
        for (int i = 0; i < 400; i++) begin
            a = $urandom; b = $urandom; cin = $urandom_range(0, 1); sub = $urandom_range(0, 1);
            in_valid = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        in_valid = 0;
        out_ready = 1;
        for (int i = 0; i < 5; i++) step();
        check("final_queue_empty", q.size(), 0);
        check("final_out_idle", out_valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cla_pipe_addsub.md
CLA_PIPE_ADDSUB -- requirements
Module: cla_pipe_addsub

Interface
REQ-001 SHALL provide parameter WIDTH, default 32, operand/result width in bits; legal values are multiples of 4, from 4 to 64.
REQ-002 SHALL provide port clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 SHALL provide port reset  input  1  synchronous, active-high reset.
REQ-004 SHALL provide port in_valid  input  1  operand set presented.
REQ-005 SHALL provide port in_ready  output  1  block accepts the operand set this cycle.
REQ-006 SHALL provide port a  input  WIDTH  operand A.
REQ-007 SHALL provide port b  input  WIDTH  operand B.
REQ-008 SHALL provide port cin  input  1  carry-in; used for add only.
REQ-009 SHALL provide port sub  input  1  0 = A+B+cin, 1 = A-B.
REQ-010 SHALL provide port out_valid  output  1  result registered and presented.
REQ-011 SHALL provide port out_ready  input  1  consumer accepts the result this cycle.
REQ-012 SHALL provide port s  output  WIDTH  sum/difference.
REQ-013 SHALL provide port co  output  1  carry out of the MSB; for sub, 1 = no borrow.
REQ-014 SHALL provide port ovf  output  1  signed overflow; present only when CLA_OVF_EN is defined.

Function
REQ-015 SHALL accept an operand set on any cycle where in_valid and in_ready are both 1, i.e. a transfer.
REQ-016 SHALL use two register stages: S1 captures a, b', c0 (b' = sub ? ~b : b; c0 = sub ? 1 : cin); S2 captures s, co and ovf.
REQ-017 SHALL compute S1->S2 using WIDTH/4 4-bit carry-lookahead groups: per-bit g = a&b', p = a^b'; group G/P; inter-group carries by lookahead over group G/P, not by per-bit ripple.
REQ-018 SHALL present a result 2 cycles after its input transfer when out_ready is held 1 (latency 2, throughput 1 per cycle).
REQ-019 SHALL compute s2_adv = !out_valid | out_ready, s1_adv = !s1_valid | s2_adv, and in_ready = s1_adv; in_ready SHALL NOT depend on in_valid.
REQ-020 SHALL hold s, co, ovf and out_valid stable while out_valid=1 and out_ready=0.
REQ-021 SHALL load S2 from S1 when s2_adv=1; out_valid then takes s1_valid.
REQ-022 SHALL keep results in transfer order with no loss or duplication under any pattern of in_valid and out_ready.
REQ-023 SHALL ignore cin whenever sub=1.
REQ-024 SHALL wrap s modulo 2^WIDTH, with the discarded carry reported on co.
REQ-025 SHALL let an input transfer and an output transfer occur in the same cycle when the pipe is full and out_ready=1.

Reset
REQ-026 SHALL, while reset=1 at a clock edge, clear s1_valid, out_valid, s, co, ovf and the S1 data registers to 0.
REQ-027 SHALL drive in_ready=0 while reset=1, and drive in_ready=1 on the first cycle after reset is released.
REQ-028 SHALL discard any in-flight operations when reset is asserted mid-operation; no result from before reset SHALL appear afterwards.

Configuration
REQ-029 SHALL implement the ovf port and its S2 register only when the macro CLA_OVF_EN is defined; ovf = carry into MSB ^ carry out of MSB.
REQ-030 SHALL, when CLA_OVF_EN is undefined, omit the ovf port entirely, with all other behaviour identical.

Verification (WIDTH=32)
REQ-031 SHALL check add: a=0xFFFFFFFF, b=0x00000001, cin=0, sub=0 -> 2 cycles later s=0x00000000, co=1, ovf=0.
REQ-032 SHALL check sub: a=0x80000000, b=0x00000001, sub=1, cin=1 (ignored) -> s=0x7FFFFFFF, co=1, ovf=1.
REQ-033 SHALL check back-pressure: 3 back-to-back transfers (1+1, 2+2, 3+3) with out_ready=0 -> in_ready=0 after the 2nd transfer; raising out_ready yields s=2, 4, 6 in order, one per cycle.
REQ-034 SHALL check reset mid-flight: 2 ops in the pipe, reset for 1 cycle -> out_valid=0 afterwards and no stale result ever emitted.
REQ-035 SHALL check throughput: 100 random transfers with in_valid=out_ready=1 -> 100 correct results, in order, 2-cycle latency, no bubbles.
REQ-036 SHALL repeat REQ-031 at WIDTH=4 and WIDTH=64, and build once without CLA_OVF_EN.
